clk_rst_seq: RTL
================

# clk_rst_seq

Reset sequencer and phase-pattern monitor sitting directly downstream of the clock block. It consumes the clock block's `locked` and its three quarter-phase-shifted clocks `c0/c1/c2`, which are registered in the `inclk0` domain and sampled here as data. It checks that the four-phase pattern is well-formed. It then releases the memory, peripheral and CPU resets in order, each release aligned to phase 0. Any loss of lock or phase fault re-asserts all resets and restarts the sequence.

## Interface
Parameters:
- `HOLD_CYCLES`, 16: consecutive valid, locked cycles required before the release sequence starts (range 1..255).
- `STAGE_GAP`, 4: minimum cycles between successive reset releases (range 1..255).

Ports:
- `inclk0` in 1: the single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `locked` in 1: lock indication from the clock block.
- `c0`, `c1`, `c2` in 1 each: phase outputs of the clock block.
- `mem_rst_n` out 1: memory-domain reset, active-low.
- `per_rst_n` out 1: peripheral-domain reset, active-low.
- `cpu_rst_n` out 1: CPU reset, active-low.
- `ready` out 1: high when all three resets are released.
- `phase_err` out 1: one-cycle pulse on an invalid phase transition.
- `fault_cnt` out 8: count of faults, saturating.

## Operation
- Pattern `{c0,c1,c2}`: P0=100, P1=110, P2=011, P3=001; the required order is P0→P1→P2→P3→P0.
  - Any other value (000, 111, 010, 101) is invalid.
- Checker:
  - `pat_q` holds the previous sample.
  - A transition is valid when the current sample equals next(`pat_q`).
  - `good_cnt` (8 b) increments when locked and the transition is valid, saturating at `HOLD_CYCLES`.
  - `good_cnt` clears on any invalid transition or when `locked` is low.
- FSM states: WAIT, HOLD, SEQ, RUN.
  - WAIT: all resets low. Go to HOLD when `locked`=1.
  - HOLD: go to SEQ when `good_cnt`==`HOLD_CYCLES`. Go back to WAIT on `locked`=0.
  - SEQ: `stage` 0..2 selects mem/per/cpu; `gap_cnt` counts cycles since the last release.
    - Release the current stage when (`stage`==0 or `gap_cnt`≥`STAGE_GAP`) and the current sample is P0.
    - Releasing the cpu stage goes to RUN.
  - RUN: `ready`=1.
- Fault = (`locked` falls) or (invalid transition) while in SEQ or RUN.
  - Next edge: all resets low, `ready` low, go to WAIT.
  - `phase_err` pulses only for an invalid transition.
  - `fault_cnt` increments for either cause and saturates at 255.
- In WAIT and HOLD, invalid transitions only clear `good_cnt`. They raise no `phase_err` and no count.
- A single 000 sample after clock-block start-up is tolerated in the same way.
- Simultaneous `locked` fall and invalid transition: `fault_cnt` +1, `phase_err` pulses.

## Timing
- `resetn` low: asynchronously forces state WAIT and all three `*_rst_n`=0.
  - Also forces `ready`=0, `phase_err`=0, `fault_cnt`=0, `pat_q`=000 and all counters 0.
- `resetn` deassertion: the first rising edge is the first functional cycle.
- All outputs are registered.
- Release occurs on the edge at which P0 is sampled, so `*_rst_n` rises one edge after the qualifying sample.
- Release spacing is at least `STAGE_GAP` cycles, rounded up to the next P0. With the defaults it is exactly 4 cycles.
- `ready` rises on the same edge as `cpu_rst_n`.
- Fault response: resets fall one edge after the faulty sample.
- `resetn` mid-sequence: outputs reset immediately with no partial release retained.

## Structure
- Package `clk_rst_pkg` holds:
  - State enum WAIT/HOLD/SEQ/RUN.
  - Constants P0..P3.
  - Function `next_phase(3 b) → 3 b`.
  - Constant `FAULT_MAX`=255.
- Sub-module `phase_checker` owns `pat_q`, `good_cnt` and the validity strobe. It outputs `valid_tr`, `invalid_tr`, `hold_met` and `at_p0`.
- The top level holds the FSM, `stage`/`gap_cnt` and the fault counter.

## Test plan
- Clean start, defaults, `locked`=1 from cycle 0, ideal pattern:
  - `mem_rst_n` rises at the first P0 after 16 valid transitions.
  - `per_rst_n` rises 4 cycles after `mem_rst_n`, `cpu_rst_n` 4 cycles after that.
  - `ready` rises with `cpu_rst_n`; `fault_cnt`=0.
- Drop `locked` for 1 cycle in RUN:
  - All resets low next edge; `fault_cnt`=1; `phase_err` stays 0.
  - Full sequence repeats after `locked` returns.
- Inject 101 in place of P2 in RUN:
  - `phase_err` one-cycle pulse; resets low next edge; `fault_cnt`=1.
- Invalid sample at transition 10 during HOLD:
  - `good_cnt` clears; no `phase_err`; `mem_rst_n` delayed by 10+ cycles; `fault_cnt`=0.
- `STAGE_GAP`=5:
  - Releases are 8 cycles apart, the next P0 after the gap expires.
- `resetn` pulsed low mid-SEQ after `mem_rst_n` released:
  - `mem_rst_n` falls asynchronously; `fault_cnt`=0; the sequence restarts from WAIT.
- Force 300 faults:
  - `fault_cnt` saturates at 255.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared constants for the reset sequencer: FSM state codes, the four legal
// {c0,c1,c2} phase patterns and their successor function.
package clk_rst_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT = 2'd0;
    localparam state_t ST_HOLD = 2'd1;
    localparam state_t ST_SEQ  = 2'd2;
    localparam state_t ST_RUN  = 2'd3;

    localparam logic [2:0] P0 = 3'b100;
    localparam logic [2:0] P1 = 3'b110;
    localparam logic [2:0] P2 = 3'b011;
    localparam logic [2:0] P3 = 3'b001;

    localparam logic [7:0] FAULT_MAX = 8'd255;

    // Illegal patterns map to 000, which is itself illegal, so nothing can
    // ever be a valid successor of a bad sample.
    function automatic logic [2:0] next_phase(input logic [2:0] pat);
        case (pat)
            P0:      next_phase = P1;
            P1:      next_phase = P2;
            P2:      next_phase = P3;
            P3:      next_phase = P0;
            default: next_phase = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/clk_rst_seq_phase_checker.sv
// Tracks the previous phase sample, flags legal/illegal transitions and
// counts consecutive locked, legal transitions up to HOLD_CYCLES.
module phase_checker
    import clk_rst_pkg::*;
#(
    parameter int HOLD_CYCLES = 16
) (
    input  logic       inclk0,
    input  logic       resetn,
    input  logic       locked,
    input  logic [2:0] sample,
    output logic       valid_tr,
    output logic       invalid_tr,
    output logic       hold_met,
    output logic       at_p0
);

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES);

    logic [2:0] pat_q;
    logic [7:0] good_cnt;

    // NOTE: strobes compare the live sample against the registered pat_q, so
    // they describe the transition being taken on the coming edge.
    assign valid_tr   = (sample == next_phase(pat_q)) && (sample != 3'b000);
    assign invalid_tr = !valid_tr;
    assign hold_met   = (good_cnt == HOLD_MAX);
    assign at_p0      = (sample == P0);

    always_ff @(posedge inclk0 or negedge resetn) begin
        if (!resetn) begin
            pat_q    <= 3'b000;
            good_cnt <= '0;
        end else begin
            pat_q <= sample;
            if (!locked || invalid_tr) begin
                good_cnt <= '0;
            end else if (good_cnt != HOLD_MAX) begin
                good_cnt <= good_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer: waits for a stable, locked four-phase pattern, then releases
// mem, per and cpu resets in order on phase 0; any fault restarts from WAIT.
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic       inclk0,
    input  logic       resetn,
    input  logic       locked,
    input  logic       c0,
    input  logic       c1,
    input  logic       c2,
    output logic       mem_rst_n,
    output logic       per_rst_n,
    output logic       cpu_rst_n,
    output logic       ready,
    output logic       phase_err,
    output logic [7:0] fault_cnt
);

    localparam logic [7:0] GAP_MIN = 8'(STAGE_GAP);

    logic       valid_tr;
    logic       invalid_tr;
    logic       hold_met;
    logic       at_p0;
    state_t     state;
    logic [1:0] stage;
    logic [7:0] gap_cnt;
    logic       fault;
    logic       release_ok;

    phase_checker #(.HOLD_CYCLES(HOLD_CYCLES)) u_checker (
        .inclk0     (inclk0),
        .resetn     (resetn),
        .locked     (locked),
        .sample     ({c0, c1, c2}),
        .valid_tr   (valid_tr),
        .invalid_tr (invalid_tr),
        .hold_met   (hold_met),
        .at_p0      (at_p0)
    );

    // SEQ/RUN are only reachable with locked high, so a low locked here is a fall.
    assign fault      = ((state == ST_SEQ) || (state == ST_RUN)) && (!locked || !valid_tr);
    assign release_ok = ((stage == 2'd0) || (gap_cnt >= GAP_MIN)) && at_p0;

    always_ff @(posedge inclk0 or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_WAIT;
            stage     <= 2'd0;
            gap_cnt   <= '0;
            mem_rst_n <= 1'b0;
            per_rst_n <= 1'b0;
            cpu_rst_n <= 1'b0;
            ready     <= 1'b0;
            phase_err <= 1'b0;
            fault_cnt <= '0;
        end else begin
            phase_err <= 1'b0;
            if (fault) begin
                state     <= ST_WAIT;
                stage     <= 2'd0;
                gap_cnt   <= '0;
                mem_rst_n <= 1'b0;
                per_rst_n <= 1'b0;
                cpu_rst_n <= 1'b0;
                ready     <= 1'b0;
                phase_err <= invalid_tr;
                if (fault_cnt != FAULT_MAX) begin
                    fault_cnt <= fault_cnt + 8'd1;
                end
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (locked) state <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (!locked) begin
                            state <= ST_WAIT;
                        end else if (hold_met) begin
                            state   <= ST_SEQ;
                            stage   <= 2'd0;
                            gap_cnt <= '0;
                        end
                    end
                    ST_SEQ: begin
                        if (release_ok) begin
                            // The releasing edge itself is cycle 1 of the next gap.
                            gap_cnt <= 8'd1;
                            stage   <= stage + 2'd1;
                            case (stage)
                                2'd0:    mem_rst_n <= 1'b1;
                                2'd1:    per_rst_n <= 1'b1;
                                default: begin
                                    cpu_rst_n <= 1'b1;
                                    ready     <= 1'b1;
                                    state     <= ST_RUN;
                                end
                            endcase
                        end else if (gap_cnt != 8'hFF) begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
